// File: rtl/mmul_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmul_stream_if
//  Purpose  : Operand / result stream bundle for mmul_stream. One element is
//             transferred per valid/ready beat in each direction.
//  Signals  : in_valid, in_data[W], in_ready     operand stream
//             out_valid, out_data[W], out_ready  result stream
//  Modports : master - producer of operands / consumer of results
//             slave  - the multiplier itself
//  Revision : 1.0 - initial release
// ============================================================================
interface mmul_stream_if #(
  parameter int W = 16
) ();
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/mmul_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mmul_stream
//  Purpose  : C = A x B for NxN signed Q(IW.FW) matrices using one shared
//             multiply-accumulate unit. Operands stream in (A row-major, then
//             B row-major), results stream out row-major.
//  Ports    : clk       clock, rising edge
//             rst       asynchronous active-high reset
//             io        mmul_stream_if.slave (in_* operand stream,
//                       out_* result stream)
//             busy      high whenever not loading operands
//             ovf       sticky: a result of the current job exceeded W bits
//  Options  : MMUL_SAT_EN - when defined, out-of-range results clamp to the
//             W-bit limits; otherwise they wrap to the low W bits.
//  Revision : 1.0 - initial release
// ============================================================================
module mmul_stream #(
  parameter int N  = 2,
  parameter int IW = 8,
  parameter int FW = 8
) (
  input  wire          clk,
  input  wire          rst,
  mmul_stream_if.slave io,
  output logic         busy,
  output logic         ovf
);

  localparam int W    = IW + FW;
  localparam int NN   = N * N;
  localparam int IDXW = $clog2(N);
  localparam int MW   = $clog2(NN);
  localparam int LDW  = $clog2(2 * NN);
  localparam int ACCW = 2 * W + $clog2(N);
  localparam int RW   = ACCW - FW;

  localparam logic [IDXW-1:0] c_LAST_IDX  = IDXW'(N - 1);
  localparam logic [LDW-1:0]  c_LAST_BEAT = LDW'(2 * NN - 1);
  localparam logic [LDW-1:0]  c_NN_BEAT   = LDW'(NN);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LDW-1:0]         r_ld_cnt;
  logic [IDXW-1:0]        r_i;
  logic [IDXW-1:0]        r_j;
  logic [IDXW-1:0]        r_k;
  logic signed [ACCW-1:0] r_acc;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [W-1:0]           r_out_data;
  logic                   r_ovf;

  logic signed [W-1:0]    r_a [NN];
  logic signed [W-1:0]    r_b [NN];

  logic                   w_xfer;
  logic                   w_mac_last;
  logic                   w_res_load;
  logic                   w_hs;
  logic                   w_last_elem;

  logic [LDW-1:0]         w_b_wr;
  logic [MW-1:0]          w_a_idx;
  logic [MW-1:0]          w_b_idx;
  logic signed [2*W-1:0]  w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_acc_base;
  logic signed [RW-1:0]   w_r;
  logic [RW-W:0]          w_r_hi;
  logic                   w_r_ovf;
  logic [W-1:0]           w_res;
  logic                   w_unused_frac;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and per-state strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_mac_last  = 1'b0;
    w_res_load  = 1'b0;
    w_hs        = 1'b0;
    w_last_elem = (r_i == c_LAST_IDX) && (r_j == c_LAST_IDX);
    case (r_state)
      ST_LOAD: begin
        w_xfer = io.in_valid && r_in_ready;
        if (w_xfer && (r_ld_cnt == c_LAST_BEAT)) w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        if (r_k == c_LAST_IDX) begin
          w_mac_last  = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        // First ST_OUT cycle registers the result; later cycles wait for
        // the consumer.
        w_res_load = !r_out_valid;
        w_hs       = r_out_valid && io.out_ready;
        if (w_hs) w_state_nxt = w_last_elem ? ST_LOAD : ST_MAC;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand stores (not reset)
  // --------------------------------------------------------------------------
  assign w_b_wr = r_ld_cnt - c_NN_BEAT;

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      if (r_ld_cnt < c_NN_BEAT) r_a[r_ld_cnt[MW-1:0]] <= io.in_data;
      else                      r_b[w_b_wr[MW-1:0]]   <= io.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Multiply-accumulate and result reduction
  // --------------------------------------------------------------------------
  assign w_a_idx    = MW'(r_i) * MW'(N) + MW'(r_k);
  assign w_b_idx    = MW'(r_k) * MW'(N) + MW'(r_j);
  assign w_prod     = r_a[w_a_idx] * r_b[w_b_idx];
  assign w_prod_ext = {{(ACCW - 2 * W){w_prod[2*W-1]}}, w_prod};
  // k == 0 starts a new dot product, so the stale sum is dropped.
  assign w_acc_base = (r_k == '0) ? '0 : r_acc;

  // Arithmetic shift by FW: keeping the upper bits floors toward -inf.
  assign w_r           = r_acc[ACCW-1:FW];
  assign w_unused_frac = ^r_acc[FW-1:0];
  // In range only if every bit from W-1 upward is a copy of the sign.
  assign w_r_hi        = w_r[RW-1:W-1];
  assign w_r_ovf       = ~((&w_r_hi) | ~(|w_r_hi));

`ifdef MMUL_SAT_EN
  always_comb begin
    w_res = w_r[W-1:0];
    if (w_r_ovf) w_res = w_r[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign w_res = w_r[W-1:0];
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_cnt    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (r_ld_cnt == '0) r_ovf <= 1'b0;
        if (r_ld_cnt == c_LAST_BEAT) begin
          r_ld_cnt   <= '0;
          r_in_ready <= 1'b0;
          r_i        <= '0;
          r_j        <= '0;
          r_k        <= '0;
        end else begin
          r_ld_cnt <= r_ld_cnt + LDW'(1);
        end
      end

      if (r_state == ST_MAC) begin
        r_acc <= w_acc_base + w_prod_ext;
        r_k   <= w_mac_last ? '0 : r_k + IDXW'(1);
      end

      if (w_res_load) begin
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
        if (w_r_ovf) r_ovf <= 1'b1;
      end

      if (w_hs) begin
        r_out_valid <= 1'b0;
        if (w_last_elem) begin
          r_i        <= '0;
          r_j        <= '0;
          r_in_ready <= 1'b1;
        end else if (r_j == c_LAST_IDX) begin
          r_j <= '0;
          r_i <= r_i + IDXW'(1);
        end else begin
          r_j <= r_j + IDXW'(1);
        end
      end
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
  assign busy         = (r_state != ST_LOAD);
  assign ovf          = r_ovf;

endmodule
`default_nettype wire
